// File: rtl/mem_access_unit_ysyx23060136.sv
// rtl/mem_access_unit_ysyx23060136.sv - MEM-stage AXI4-Lite load/store engine
//
// Purpose:
//   Turns the one-cycle load/store pulses coming out of the EX/MEM segment
//   register into single AXI4-Lite read or write transactions. It raises a
//   stall request while a transaction is in flight and returns size-formatted,
//   sign/zero-extended load data to the MEM/WB path with a one-cycle done pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   MEM_i_raddr_change        load request pulse (wins over a same-cycle store)
//   MEM_i_waddr_change        store request pulse
//   MEM_i_ALU_ALUout          effective byte address
//   MEM_i_rs2_data            store data, low bits valid
//   MEM_i_mem_*               one-hot access size / signedness
//   ar*, r*                   AXI4-Lite read address / read data channels
//   aw*, w*, b*               AXI4-Lite write address / data / response channels
//   MEM_o_rdata               formatted load result, valid with MEM_o_done
//   MEM_o_done                one-cycle completion pulse
//   MEM_o_busy                stall request to the forward unit
//   MEM_o_err                 qualifies MEM_o_done: misaligned or non-OKAY response

module mem_access_unit_ysyx23060136 #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  MEM_i_raddr_change,
   input  logic                  MEM_i_waddr_change,
   input  logic [31:0]           MEM_i_ALU_ALUout,
   input  logic [31:0]           MEM_i_rs2_data,
   input  logic                  MEM_i_mem_byte,
   input  logic                  MEM_i_mem_half,
   input  logic                  MEM_i_mem_word,
   input  logic                  MEM_i_mem_byte_u,
   input  logic                  MEM_i_mem_half_u,

   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,

   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready,

   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic                  awvalid,
   input  logic                  awready,

   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   output logic                  wvalid,
   input  logic                  wready,

   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,

   output logic [31:0]           MEM_o_rdata,
   output logic                  MEM_o_done,
   output logic                  MEM_o_busy,
   output logic                  MEM_o_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_RESP,
      S_FAULT
   } state_e;

   state_e                  state_q, state_d;

   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic                    awvalid_q, awvalid_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;

   // Load formatting context, captured when the load is accepted.
   logic [1:0]              off_q, off_d;
   logic                    ld_byte_q, ld_byte_d;
   logic                    ld_byte_u_q, ld_byte_u_d;
   logic                    ld_half_q, ld_half_d;
   logic                    ld_half_u_q, ld_half_u_d;

   logic [31:0]             rdata_q, rdata_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   // Request decode from the EX/MEM register
   logic                    req_half;
   logic                    req_misaligned;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [3:0]              st_wstrb;
   logic [31:0]             st_wdata;

   // Load data formatting
   logic [7:0]              ld_byte_sel;
   logic [15:0]             ld_half_sel;
   logic [31:0]             ld_fmt;

   // Write channel: a channel counts as accepted once its valid has dropped
   // or it is handshaking in the current cycle.
   logic                    aw_ok;
   logic                    w_ok;

   assign req_half       = MEM_i_mem_half | MEM_i_mem_half_u;
   assign req_misaligned = (req_half & MEM_i_ALU_ALUout[0])
                         | (MEM_i_mem_word & (MEM_i_ALU_ALUout[1:0] != 2'b00));
   assign req_addr       = ADDR_WIDTH'(MEM_i_ALU_ALUout);

   always_comb begin
      st_wstrb = 4'hF;
      st_wdata = MEM_i_rs2_data;
      if (MEM_i_mem_byte) begin
         st_wstrb = 4'b0001 << MEM_i_ALU_ALUout[1:0];
         st_wdata = {4{MEM_i_rs2_data[7:0]}};
      end else if (req_half) begin
         st_wstrb = 4'b0011 << {MEM_i_ALU_ALUout[1], 1'b0};
         st_wdata = {2{MEM_i_rs2_data[15:0]}};
      end
   end

   // Lane selection is equivalent to shifting rdata right by 8*offset.
   always_comb begin
      ld_byte_sel = rdata[7:0];
      case (off_q)
         2'd0:    ld_byte_sel = rdata[7:0];
         2'd1:    ld_byte_sel = rdata[15:8];
         2'd2:    ld_byte_sel = rdata[23:16];
         default: ld_byte_sel = rdata[31:24];
      endcase
      ld_half_sel = off_q[1] ? rdata[31:16] : rdata[15:0];

      ld_fmt = rdata;
      if (ld_byte_q) begin
         ld_fmt = {{24{ld_byte_sel[7]}}, ld_byte_sel};
      end else if (ld_byte_u_q) begin
         ld_fmt = {24'h0, ld_byte_sel};
      end else if (ld_half_q) begin
         ld_fmt = {{16{ld_half_sel[15]}}, ld_half_sel};
      end else if (ld_half_u_q) begin
         ld_fmt = {16'h0, ld_half_sel};
      end
   end

   assign aw_ok = ~awvalid_q | awready;
   assign w_ok  = ~wvalid_q  | wready;

   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      awaddr_d    = awaddr_q;
      awvalid_d   = awvalid_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      off_d       = off_q;
      ld_byte_d   = ld_byte_q;
      ld_byte_u_d = ld_byte_u_q;
      ld_half_d   = ld_half_q;
      ld_half_u_d = ld_half_u_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (MEM_i_raddr_change) begin
               off_d       = MEM_i_ALU_ALUout[1:0];
               ld_byte_d   = MEM_i_mem_byte;
               ld_byte_u_d = MEM_i_mem_byte_u;
               ld_half_d   = MEM_i_mem_half;
               ld_half_u_d = MEM_i_mem_half_u;
               if (req_misaligned) begin
                  state_d = S_FAULT;
               end else begin
                  state_d   = S_RD_ADDR;
                  araddr_d  = req_addr;
                  arvalid_d = 1'b1;
               end
            end else if (MEM_i_waddr_change) begin
               if (req_misaligned) begin
                  state_d = S_FAULT;
               end else begin
                  state_d   = S_WR_REQ;
                  awaddr_d  = req_addr;
                  awvalid_d = 1'b1;
                  wdata_d   = st_wdata;
                  wstrb_d   = st_wstrb;
                  wvalid_d  = 1'b1;
               end
            end
         end

         S_RD_ADDR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end

         S_RD_DATA: begin
            if (rvalid) begin
               rready_d = 1'b0;
               state_d  = S_IDLE;
               done_d   = 1'b1;
               err_d    = (rresp != 2'b00);
               rdata_d  = ld_fmt;
            end
         end

         S_WR_REQ: begin
            if (awready) begin
               awvalid_d = 1'b0;
            end
            if (wready) begin
               wvalid_d = 1'b0;
            end
            if (aw_ok && w_ok) begin
               bready_d = 1'b1;
               state_d  = S_WR_RESP;
            end
         end

         S_WR_RESP: begin
            if (bvalid) begin
               bready_d = 1'b0;
               state_d  = S_IDLE;
               done_d   = 1'b1;
               err_d    = (bresp != 2'b00);
               rdata_d  = 32'h0;
            end
         end

         S_FAULT: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         off_q       <= 2'b00;
         ld_byte_q   <= 1'b0;
         ld_byte_u_q <= 1'b0;
         ld_half_q   <= 1'b0;
         ld_half_u_q <= 1'b0;
         rdata_q     <= 32'h0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         awaddr_q    <= awaddr_d;
         awvalid_q   <= awvalid_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         off_q       <= off_d;
         ld_byte_q   <= ld_byte_d;
         ld_byte_u_q <= ld_byte_u_d;
         ld_half_q   <= ld_half_d;
         ld_half_u_q <= ld_half_u_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign araddr      = araddr_q;
   assign arvalid     = arvalid_q;
   assign rready      = rready_q;
   assign awaddr      = awaddr_q;
   assign awvalid     = awvalid_q;
   assign wdata       = wdata_q;
   assign wstrb       = wstrb_q;
   assign wvalid      = wvalid_q;
   assign bready      = bready_q;
   assign MEM_o_rdata = rdata_q;
   assign MEM_o_done  = done_q;
   assign MEM_o_err   = err_q;

   // The stall must cover the pulse cycle itself, before the FSM has moved.
   assign MEM_o_busy  = (state_q != S_IDLE)
                      | (MEM_i_raddr_change | MEM_i_waddr_change);

endmodule

// File: tb/tb_mem_access_unit_ysyx23060136.sv
// tb/tb_mem_access_unit_ysyx23060136.sv - self-checking bench for the MEM-stage load/store engine

module tb_mem_access_unit_ysyx23060136;

   localparam int AW = 32;
   localparam logic [4:0] FL_B  = 5'b10000;
   localparam logic [4:0] FL_H  = 5'b01000;
   localparam logic [4:0] FL_W  = 5'b00100;
   localparam logic [4:0] FL_BU = 5'b00010;
   localparam logic [4:0] FL_HU = 5'b00001;

   logic          clk = 1'b0;
   logic          rst;
   logic          raddr_chg, waddr_chg;
   logic [31:0]   alu_out, rs2_data;
   logic          f_byte, f_half, f_word, f_byte_u, f_half_u;
   logic [AW-1:0] araddr, awaddr;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   rdata, wdata;
   logic [1:0]    rresp, bresp;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]    wstrb;
   logic [31:0]   mem_rdata;
   logic          mem_done, mem_busy, mem_err;

   always #5 clk = ~clk;

   mem_access_unit_ysyx23060136 #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .MEM_i_raddr_change(raddr_chg), .MEM_i_waddr_change(waddr_chg),
      .MEM_i_ALU_ALUout(alu_out), .MEM_i_rs2_data(rs2_data),
      .MEM_i_mem_byte(f_byte), .MEM_i_mem_half(f_half), .MEM_i_mem_word(f_word),
      .MEM_i_mem_byte_u(f_byte_u), .MEM_i_mem_half_u(f_half_u),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .MEM_o_rdata(mem_rdata), .MEM_o_done(mem_done),
      .MEM_o_busy(mem_busy), .MEM_o_err(mem_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pulse_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Slave model: readiness per channel after a programmable wait.
   int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   logic [31:0] rdata_val = 32'h0;
   logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;
   int          ar_count = 0, aw_count = 0, w_count = 0;
   logic [31:0] araddr_seen = 32'h0, awaddr_seen = 32'h0, wdata_seen = 32'h0;
   logic [3:0]  wstrb_seen = 4'h0;
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

   initial begin
      arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         end else begin
            if (arvalid) begin
               if (ar_cnt >= ar_delay) begin
                  arready = 1'b1; araddr_seen = araddr; ar_count++;
               end else begin
                  arready = 1'b0; ar_cnt++;
               end
            end else begin
               arready = 1'b0; ar_cnt = 0;
            end
            if (rready) begin
               if (r_cnt >= r_delay) begin
                  rvalid = 1'b1; rdata = rdata_val; rresp = rresp_val;
               end else begin
                  rvalid = 1'b0; rdata = 32'hDEAD_BEEF; rresp = 2'b00; r_cnt++;
               end
            end else begin
               rvalid = 1'b0; rdata = 32'hDEAD_BEEF; rresp = 2'b00; r_cnt = 0;
            end
            if (awvalid) begin
               if (aw_cnt >= aw_delay) begin
                  awready = 1'b1; awaddr_seen = awaddr; aw_count++;
               end else begin
                  awready = 1'b0; aw_cnt++;
               end
            end else begin
               awready = 1'b0; aw_cnt = 0;
            end
            if (wvalid) begin
               if (w_cnt >= w_delay) begin
                  wready = 1'b1; wdata_seen = wdata; wstrb_seen = wstrb; w_count++;
               end else begin
                  wready = 1'b0; w_cnt++;
               end
            end else begin
               wready = 1'b0; w_cnt = 0;
            end
            if (bready) begin
               if (b_cnt >= b_delay) begin
                  bvalid = 1'b1; bresp = bresp_val;
               end else begin
                  bvalid = 1'b0; bresp = 2'b00; b_cnt++;
               end
            end else begin
               bvalid = 1'b0; bresp = 2'b00; b_cnt = 0;
            end
         end
      end
   end

   // Scoreboard: expectations pushed at issue, popped on each done pulse.
   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];
   exp_t sb_e;
   int   done_count = 0;
   bit   w_first_seen = 1'b0;

   initial forever begin
      @(negedge clk);
      if (wvalid === 1'b0 && awvalid === 1'b1) w_first_seen = 1'b1;
      if (mem_done === 1'b1) begin
         done_count++;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: actual=done pulse required=no pulse (rdata=0x%08h)", mem_rdata);
         end else begin
            sb_e = sb.pop_front();
            check("sb_rdata", mem_rdata, sb_e.rdata);
            check("sb_err", {31'h0, mem_err}, {31'h0, sb_e.err});
         end
      end
   end

   task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] fl);
      @(posedge clk);
      #1;
      raddr_chg = rd;
      waddr_chg = wr;
      alu_out   = addr;
      rs2_data  = data;
      {f_byte, f_half, f_word, f_byte_u, f_half_u} = fl;
      pulse_cyc = cyc;
      @(negedge clk);
      check("busy_on_pulse", {31'h0, mem_busy}, 32'd1);
      @(posedge clk);
      #1;
      raddr_chg = 1'b0;
      waddr_chg = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit chk_busy, output int lat);
      bit got = 1'b0;
      bit gap = 1'b0;
      lat = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (mem_done === 1'b1) begin
            got = 1'b1;
            lat = cyc - pulse_cyc;
            if (chk_busy) check("busy_low_in_done", {31'h0, mem_busy}, 32'd0);
            break;
         end
         if (chk_busy && mem_busy !== 1'b1) gap = 1'b1;
      end
      check("done_seen", {31'h0, got}, 32'd1);
      if (chk_busy) check("busy_held", {31'h0, gap}, 32'd0);
   endtask

   typedef struct {
      bit          st;
      logic [4:0]  fl;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      bit          fault;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs[NV];
   int   lat, ar0, aw0, dc0;
   bit   seen;

   initial begin
      vecs[0]  = '{0, FL_B,  32'h8000_0003, 32'h80FF_FF11, 2'b00, 0, 32'hFFFF_FF80, 1'b0, 32'h0, 4'h0};
      vecs[1]  = '{0, FL_BU, 32'h8000_0003, 32'h80FF_FF11, 2'b00, 0, 32'h0000_0080, 1'b0, 32'h0, 4'h0};
      vecs[2]  = '{0, FL_H,  32'h8000_0002, 32'h80FF_FF11, 2'b00, 0, 32'hFFFF_80FF, 1'b0, 32'h0, 4'h0};
      vecs[3]  = '{0, FL_HU, 32'h0000_0000, 32'h1234_8765, 2'b00, 0, 32'h0000_8765, 1'b0, 32'h0, 4'h0};
      vecs[4]  = '{0, FL_W,  32'h8000_0004, 32'hCAFE_BABE, 2'b00, 0, 32'hCAFE_BABE, 1'b0, 32'h0, 4'h0};
      vecs[5]  = '{0, FL_B,  32'h0000_0001, 32'h1234_5678, 2'b00, 0, 32'h0000_0056, 1'b0, 32'h0, 4'h0};
      vecs[6]  = '{0, FL_W,  32'h0000_0008, 32'h1111_2222, 2'b10, 0, 32'h1111_2222, 1'b1, 32'h0, 4'h0};
      vecs[7]  = '{1, FL_H,  32'h8000_0002, 32'h1234_ABCD, 2'b00, 0, 32'h0, 1'b0, 32'hABCD_ABCD, 4'b1100};
      vecs[8]  = '{1, FL_B,  32'h8000_0001, 32'h0000_00A5, 2'b00, 0, 32'h0, 1'b0, 32'hA5A5_A5A5, 4'b0010};
      vecs[9]  = '{1, FL_W,  32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0, 32'h0, 1'b0, 32'hDEAD_BEEF, 4'b1111};
      vecs[10] = '{1, FL_B,  32'h0000_0003, 32'h0000_0077, 2'b00, 0, 32'h0, 1'b0, 32'h7777_7777, 4'b1000};
      vecs[11] = '{1, FL_W,  32'h0000_0020, 32'h0BAD_F00D, 2'b11, 0, 32'h0, 1'b1, 32'h0BAD_F00D, 4'b1111};
      vecs[12] = '{0, FL_W,  32'h8000_0001, 32'h1234_5678, 2'b00, 1, 32'h0, 1'b1, 32'h0, 4'h0};
      vecs[13] = '{1, FL_H,  32'h0000_0003, 32'h5555_5555, 2'b00, 1, 32'h0, 1'b1, 32'h0, 4'h0};
      vecs[14] = '{0, FL_HU, 32'h0000_0001, 32'h1234_5678, 2'b00, 1, 32'h0, 1'b1, 32'h0, 4'h0};
      vecs[15] = '{1, FL_H,  32'h0000_0000, 32'hFFFF_1234, 2'b00, 0, 32'h0, 1'b0, 32'h1234_1234, 4'b0011};
      vecs[16] = '{0, FL_H,  32'h0000_0000, 32'h0000_8001, 2'b00, 0, 32'hFFFF_8001, 1'b0, 32'h0, 4'h0};
      vecs[17] = '{0, FL_B,  32'h0000_0002, 32'h00FE_0000, 2'b00, 0, 32'hFFFF_FFFE, 1'b0, 32'h0, 4'h0};

      rst = 1'b1;
      raddr_chg = 1'b0; waddr_chg = 1'b0;
      alu_out = 32'h0; rs2_data = 32'h0;
      {f_byte, f_half, f_word, f_byte_u, f_half_u} = 5'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_arvalid", {31'h0, arvalid}, 32'd0);
      check("rst_rready",  {31'h0, rready},  32'd0);
      check("rst_awvalid", {31'h0, awvalid}, 32'd0);
      check("rst_wvalid",  {31'h0, wvalid},  32'd0);
      check("rst_bready",  {31'h0, bready},  32'd0);
      check("rst_araddr",  araddr, 32'h0);
      check("rst_awaddr",  awaddr, 32'h0);
      check("rst_wdata",   wdata,  32'h0);
      check("rst_wstrb",   {28'h0, wstrb}, 32'h0);
      check("rst_rdata",   mem_rdata, 32'h0);
      check("rst_done_err_busy", {29'h0, mem_done, mem_err, mem_busy}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Table-driven single transactions against a zero-wait slave
      for (int i = 0; i < NV; i++) begin
         rdata_val = vecs[i].data;
         rresp_val = vecs[i].resp;
         bresp_val = vecs[i].resp;
         ar0 = ar_count;
         aw0 = aw_count;
         sb.push_back('{vecs[i].exp_rdata, vecs[i].exp_err});
         issue(!vecs[i].st, vecs[i].st, vecs[i].addr, vecs[i].data, vecs[i].fl);
         wait_done(20, 1'b1, lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].fault ? 32'd2 : 32'd3);
         if (vecs[i].fault) begin
            check($sformatf("v%0d_no_ar", i), ar_count, ar0);
            check($sformatf("v%0d_no_aw", i), aw_count, aw0);
         end else if (vecs[i].st) begin
            check($sformatf("v%0d_awaddr", i), awaddr_seen, vecs[i].addr);
            check($sformatf("v%0d_wdata", i), wdata_seen, vecs[i].exp_wdata);
            check($sformatf("v%0d_wstrb", i), {28'h0, wstrb_seen}, {28'h0, vecs[i].exp_wstrb});
         end else begin
            check($sformatf("v%0d_araddr", i), araddr_seen, vecs[i].addr);
         end
      end
      rresp_val = 2'b00;
      bresp_val = 2'b00;

      // Write data accepted three cycles before the address
      aw_delay = 3;
      w_first_seen = 1'b0;
      sb.push_back('{32'h0, 1'b0});
      issue(1'b0, 1'b1, 32'h8000_0040, 32'h0102_0304, FL_W);
      wait_done(30, 1'b1, lat);
      check("wfirst_seen", {31'h0, w_first_seen}, 32'd1);
      check("wfirst_latency", lat, 32'd6);
      check("wfirst_awaddr", awaddr_seen, 32'h8000_0040);
      check("wfirst_wdata", wdata_seen, 32'h0102_0304);
      aw_delay = 0;

      // Slow slave with SLVERR on a halfword unsigned load
      r_delay = 5;
      rresp_val = 2'b10;
      rdata_val = 32'h1234_F00D;
      sb.push_back('{32'h0000_F00D, 1'b1});
      issue(1'b1, 1'b0, 32'h0000_0000, 32'h0, FL_HU);
      wait_done(30, 1'b1, lat);
      check("slow_latency", lat, 32'd8);
      rresp_val = 2'b00;

      // Reset while waiting in the read data phase
      r_delay = 10;
      issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, FL_W);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rready === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("rst_mid_reached_rd_data", {31'h0, seen}, 32'd1);
      dc0 = done_count;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid_rready", {31'h0, rready}, 32'd0);
      check("rst_mid_busy", {31'h0, mem_busy}, 32'd0);
      check("rst_mid_arvalid", {31'h0, arvalid}, 32'd0);
      repeat (12) @(negedge clk);
      check("rst_mid_no_done", done_count, dc0);
      r_delay = 0;

      // Load and store pulses together: the load wins
      rdata_val = 32'hA5A5_5A5A;
      ar0 = ar_count;
      aw0 = aw_count;
      sb.push_back('{32'hA5A5_5A5A, 1'b0});
      issue(1'b1, 1'b1, 32'h0000_0044, 32'h0000_9999, FL_W);
      wait_done(20, 1'b1, lat);
      check("both_ar_count", ar_count, ar0 + 1);
      check("both_aw_count", aw_count, aw0);
      check("both_araddr", araddr_seen, 32'h0000_0044);

      // Store pulse arriving mid-load is ignored
      r_delay = 3;
      rdata_val = 32'h0BAD_CAFE;
      aw0 = aw_count;
      dc0 = done_count;
      sb.push_back('{32'h0BAD_CAFE, 1'b0});
      issue(1'b1, 1'b0, 32'h0000_0050, 32'h0, FL_W);
      issue(1'b0, 1'b1, 32'h0000_0060, 32'h1111_1111, FL_W);
      wait_done(20, 1'b0, lat);
      repeat (6) @(negedge clk);
      check("ignored_done_count", done_count, dc0 + 1);
      check("ignored_aw_count", aw_count, aw0);
      r_delay = 0;

      check("sb_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
